// File: rtl/threshold_monitor.sv
// threshold_monitor: debounced hysteresis classifier for an unsigned sample stream.
// Emits rise/fall event pulses and tracks running max, min and sample count.
module threshold_monitor #(
   parameter int WIDTH    = 32,
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] thresh_hi,
   input  logic [WIDTH-1:0] thresh_lo,
   input  logic             clear,
   output logic             level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [WIDTH-1:0] max_o,
   output logic [WIDTH-1:0] min_o,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             out_valid
);

   localparam int DCNT_W = $clog2(DEBOUNCE + 1);
   // dcnt value that, once incremented by one more qualifying sample, commits the run
   localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_RISE_PEND,
      ST_HIGH,
      ST_FALL_PEND
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DCNT_W-1:0] dcnt;
   logic [DCNT_W-1:0] dcnt_nxt;
   logic              rise_nxt;
   logic              fall_nxt;
   logic              accept;
   logic              above;
   logic              below;
   logic              seen;

   assign accept = in_valid & ~clear;
   assign above  = in_data > thresh_hi;
   assign below  = in_data < thresh_lo;

   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (clear) begin
         state_nxt = ST_LOW;
         dcnt_nxt  = '0;
      end else if (in_valid) begin
         case (state)
            ST_LOW: begin
               if (above) begin
                  if (DEBOUNCE == 1) begin
                     state_nxt = ST_HIGH;
                     rise_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_RISE_PEND;
                     dcnt_nxt  = DCNT_W'(1);
                  end
               end
            end
            ST_RISE_PEND: begin
               if (above) begin
                  if (dcnt == DEB_LAST) begin
                     state_nxt = ST_HIGH;
                     rise_nxt  = 1'b1;
                     dcnt_nxt  = '0;
                  end else begin
                     dcnt_nxt = dcnt + DCNT_W'(1);
                  end
               end else begin
                  state_nxt = ST_LOW;
                  dcnt_nxt  = '0;
               end
            end
            ST_HIGH: begin
               if (below) begin
                  if (DEBOUNCE == 1) begin
                     state_nxt = ST_LOW;
                     fall_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_FALL_PEND;
                     dcnt_nxt  = DCNT_W'(1);
                  end
               end
            end
            ST_FALL_PEND: begin
               if (below) begin
                  if (dcnt == DEB_LAST) begin
                     state_nxt = ST_LOW;
                     fall_nxt  = 1'b1;
                     dcnt_nxt  = '0;
                  end else begin
                     dcnt_nxt = dcnt + DCNT_W'(1);
                  end
               end else begin
                  state_nxt = ST_HIGH;
                  dcnt_nxt  = '0;
               end
            end
            default: begin
               state_nxt = ST_LOW;
               dcnt_nxt  = '0;
            end
         endcase
      end
   end

   // level is registered from the next state so it lines up with the pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LOW;
         dcnt       <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         dcnt       <= dcnt_nxt;
         level      <= (state_nxt == ST_HIGH) || (state_nxt == ST_FALL_PEND);
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
         out_valid  <= accept;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_o      <= '0;
         min_o      <= '0;
         sample_cnt <= '0;
         seen       <= 1'b0;
      end else if (clear) begin
         max_o      <= '0;
         min_o      <= '0;
         sample_cnt <= '0;
         seen       <= 1'b0;
      end else if (in_valid) begin
         seen <= 1'b1;
         if (!seen) begin
            max_o <= in_data;
            min_o <= in_data;
         end else begin
            if (in_data > max_o) max_o <= in_data;
            if (in_data < min_o) min_o <= in_data;
         end
         if (sample_cnt != {CNT_W{1'b1}}) sample_cnt <= sample_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_threshold_monitor.sv
// tb_threshold_monitor: table, directed and randomized checks of threshold_monitor
// against a sample-level behavioural model, using two parameterizations.
module tb_threshold_monitor;

   localparam int W     = 32;
   localparam int DEB_A = 4;
   localparam int CNT_A = 16;
   localparam int DEB_B = 1;
   localparam int CNT_B = 2;
   localparam longint CMAX_A = (64'd1 << CNT_A) - 1;
   localparam longint CMAX_B = (64'd1 << CNT_B) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         clear = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [W-1:0] thresh_hi = '0;
   logic [W-1:0] thresh_lo = '0;

   logic             level_a, rise_a, fall_a, ov_a;
   logic [W-1:0]     max_a, min_a;
   logic [CNT_A-1:0] cnt_a;
   logic             level_b, rise_b, fall_b, ov_b;
   logic [W-1:0]     max_b, min_b;
   logic [CNT_B-1:0] cnt_b;

   threshold_monitor #(.WIDTH(W), .DEBOUNCE(DEB_A), .CNT_W(CNT_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .clear(clear),
      .level(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
      .max_o(max_a), .min_o(min_a), .sample_cnt(cnt_a), .out_valid(ov_a)
   );

   threshold_monitor #(.WIDTH(W), .DEBOUNCE(DEB_B), .CNT_W(CNT_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .clear(clear),
      .level(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
      .max_o(max_b), .min_o(min_b), .sample_cnt(cnt_b), .out_valid(ov_b)
   );

   always #5 clk = ~clk;

   // Model: current level plus the length of the qualifying run since the last commit
   typedef struct {
      bit           level;
      int           run;
      bit           rise;
      bit           fall;
      bit           ov;
      logic [W-1:0] mx;
      logic [W-1:0] mn;
      bit           seen;
      longint       cnt;
   } model_t;

   typedef struct {
      bit           v;
      logic [W-1:0] d;
      bit           level;
      bit           rise;
      bit           fall;
      bit           ov;
      logic [W-1:0] mx;
      logic [W-1:0] mn;
      int           cnt;
   } vec_t;

   model_t ma, mb;
   vec_t   tbl[12];
   int     vectors = 0;
   int     miscompares = 0;
   bit     gap_v[8];
   bit     mode;
   bit     rv;
   bit     rc;
   logic [W-1:0] rhi, rlo, rd;

   function automatic model_t modelReset();
      model_t m;
      m.level = 1'b0; m.run = 0; m.rise = 1'b0; m.fall = 1'b0; m.ov = 1'b0;
      m.mx = '0; m.mn = '0; m.seen = 1'b0; m.cnt = 0;
      return m;
   endfunction

   function automatic model_t modelStep(model_t m, int deb, longint cmax, bit v, bit clr,
                                        logic [W-1:0] d, logic [W-1:0] hi, logic [W-1:0] lo);
      model_t n;
      bit     qual;
      n = m;
      n.rise = 1'b0;
      n.fall = 1'b0;
      n.ov   = v && !clr;
      if (clr) begin
         n = modelReset();
         return n;
      end
      if (!v) return n;
      qual = n.level ? (d < lo) : (d > hi);
      if (qual) begin
         n.run = n.run + 1;
         if (n.run == deb) begin
            n.level = !n.level;
            n.rise  = n.level;
            n.fall  = !n.level;
            n.run   = 0;
         end
      end else begin
         n.run = 0;
      end
      if (!n.seen) begin
         n.mx = d; n.mn = d; n.seen = 1'b1;
      end else begin
         if (d > n.mx) n.mx = d;
         if (d < n.mn) n.mn = d;
      end
      if (n.cnt < cmax) n.cnt = n.cnt + 1;
      return n;
   endfunction

   function automatic vec_t mkVec(bit v, logic [W-1:0] d, bit l, bit r, bit f, bit ov,
                                  logic [W-1:0] mx, logic [W-1:0] mn, int cnt);
      vec_t t;
      t.v = v; t.d = d; t.level = l; t.rise = r; t.fall = f; t.ov = ov;
      t.mx = mx; t.mn = mn; t.cnt = cnt;
      return t;
   endfunction

   task automatic checkVal(string name, logic [63:0] got, logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic checkOutput(string tag);
      checkVal({tag, ".a.level"}, level_a, ma.level);
      checkVal({tag, ".a.rise"},  rise_a,  ma.rise);
      checkVal({tag, ".a.fall"},  fall_a,  ma.fall);
      checkVal({tag, ".a.ov"},    ov_a,    ma.ov);
      checkVal({tag, ".a.max"},   max_a,   ma.mx);
      checkVal({tag, ".a.min"},   min_a,   ma.mn);
      checkVal({tag, ".a.cnt"},   cnt_a,   ma.cnt);
      checkVal({tag, ".b.level"}, level_b, mb.level);
      checkVal({tag, ".b.rise"},  rise_b,  mb.rise);
      checkVal({tag, ".b.fall"},  fall_b,  mb.fall);
      checkVal({tag, ".b.ov"},    ov_b,    mb.ov);
      checkVal({tag, ".b.max"},   max_b,   mb.mx);
      checkVal({tag, ".b.min"},   min_b,   mb.mn);
      checkVal({tag, ".b.cnt"},   cnt_b,   mb.cnt);
   endtask

   task automatic checkResetValues(string tag);
      checkVal({tag, ".level"}, {level_a, level_b}, 0);
      checkVal({tag, ".pulses"}, {rise_a, fall_a, rise_b, fall_b}, 0);
      checkVal({tag, ".ov"}, {ov_a, ov_b}, 0);
      checkVal({tag, ".max_a"}, max_a, 0);
      checkVal({tag, ".min_a"}, min_a, 0);
      checkVal({tag, ".max_b"}, max_b, 0);
      checkVal({tag, ".min_b"}, min_b, 0);
      checkVal({tag, ".cnt"}, {cnt_a, cnt_b}, 0);
   endtask

   task automatic applyStimulus(bit v, bit clr, logic [W-1:0] d, logic [W-1:0] hi, logic [W-1:0] lo);
      in_valid  = v;
      clear     = clr;
      in_data   = d;
      thresh_hi = hi;
      thresh_lo = lo;
      @(posedge clk);
      #1;
      ma = modelStep(ma, DEB_A, CMAX_A, v, clr, d, hi, lo);
      mb = modelStep(mb, DEB_B, CMAX_B, v, clr, d, hi, lo);
      checkOutput("step");
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      #1;
      checkResetValues("reset");
      ma = modelReset();
      mb = modelReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Rise after four 101s, then a fall broken once by 60, then an idle cycle
      tbl[0]  = mkVec(1'b1, 101, 1'b0, 1'b0, 1'b0, 1'b1, 101, 101, 1);
      tbl[1]  = mkVec(1'b1, 101, 1'b0, 1'b0, 1'b0, 1'b1, 101, 101, 2);
      tbl[2]  = mkVec(1'b1, 101, 1'b0, 1'b0, 1'b0, 1'b1, 101, 101, 3);
      tbl[3]  = mkVec(1'b1, 101, 1'b1, 1'b1, 1'b0, 1'b1, 101, 101, 4);
      tbl[4]  = mkVec(1'b1, 49,  1'b1, 1'b0, 1'b0, 1'b1, 101, 49, 5);
      tbl[5]  = mkVec(1'b1, 49,  1'b1, 1'b0, 1'b0, 1'b1, 101, 49, 6);
      tbl[6]  = mkVec(1'b1, 60,  1'b1, 1'b0, 1'b0, 1'b1, 101, 49, 7);
      tbl[7]  = mkVec(1'b1, 49,  1'b1, 1'b0, 1'b0, 1'b1, 101, 49, 8);
      tbl[8]  = mkVec(1'b1, 49,  1'b1, 1'b0, 1'b0, 1'b1, 101, 49, 9);
      tbl[9]  = mkVec(1'b1, 49,  1'b1, 1'b0, 1'b0, 1'b1, 101, 49, 10);
      tbl[10] = mkVec(1'b1, 49,  1'b0, 1'b0, 1'b1, 1'b1, 101, 49, 11);
      tbl[11] = mkVec(1'b0, 0,   1'b0, 1'b0, 1'b0, 1'b0, 101, 49, 11);
      gap_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      ma = modelReset();
      mb = modelReset();
      repeat (2) @(posedge clk);
      #1;
      doReset();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].v, 1'b0, tbl[i].d, 100, 50);
         checkVal("tbl.level", level_a, tbl[i].level);
         checkVal("tbl.rise",  rise_a,  tbl[i].rise);
         checkVal("tbl.fall",  fall_a,  tbl[i].fall);
         checkVal("tbl.ov",    ov_a,    tbl[i].ov);
         checkVal("tbl.max",   max_a,   tbl[i].mx);
         checkVal("tbl.min",   min_a,   tbl[i].mn);
         checkVal("tbl.cnt",   cnt_a,   tbl[i].cnt);
      end

      // Equality with either threshold never qualifies
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 100, 100, 50);
         checkVal("eq_hi.level", {level_a, level_b}, 0);
         checkVal("eq_hi.rise", {rise_a, rise_b}, 0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 101, 100, 50);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 50, 100, 50);
         checkVal("eq_lo.level", {level_a, level_b}, 2'b11);
         checkVal("eq_lo.fall", {fall_a, fall_b}, 0);
      end

      // Idle gaps do not break a debounce run
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(gap_v[i], 1'b0, gap_v[i] ? 101 : 7, 100, 50);
         checkVal("gap.ov", ov_a, gap_v[i]);
         checkVal("gap.rise", rise_a, i == 7);
      end
      checkVal("gap.level", level_a, 1);
      checkVal("gap.cnt", cnt_a, 4);

      // Clear beats a simultaneous sample and re-arms the first-sample load
      doReset();
      applyStimulus(1'b1, 1'b0, 7, 100, 50);
      applyStimulus(1'b1, 1'b0, 3, 100, 50);
      applyStimulus(1'b1, 1'b0, 9, 100, 50);
      checkVal("pre_clr.max", max_a, 9);
      checkVal("pre_clr.min", min_a, 3);
      applyStimulus(1'b1, 1'b1, 200, 100, 50);
      checkVal("clr.max", max_a, 0);
      checkVal("clr.min", min_a, 0);
      checkVal("clr.cnt", cnt_a, 0);
      checkVal("clr.ov", ov_a, 0);
      applyStimulus(1'b1, 1'b0, 5, 100, 50);
      checkVal("post_clr.max", max_a, 5);
      checkVal("post_clr.min", min_a, 5);
      checkVal("post_clr.cnt", cnt_a, 1);

      // Narrow counter saturates instead of wrapping
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 10, 100, 50);
         checkVal("sat.cnt_b", cnt_b, (i < 3) ? i + 1 : 3);
      end

      // Asynchronous reset mid-run clears outputs without an edge and discards the run
      doReset();
      applyStimulus(1'b1, 1'b0, 101, 100, 50);
      applyStimulus(1'b1, 1'b0, 101, 100, 50);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("async");
      ma = modelReset();
      mb = modelReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 101, 100, 50);
      applyStimulus(1'b1, 1'b0, 101, 100, 50);
      checkVal("async.no_rise", {rise_a, level_a}, 0);

      // Randomized blocks with fixed thresholds and a sticky bias above/below the window
      doReset();
      for (int blk = 0; blk < 15; blk++) begin
         rhi  = $urandom_range(60, 40);
         rlo  = $urandom_range(55, 30);
         mode = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(7, 0) == 0) mode = !mode;
            rv = ($urandom_range(3, 0) != 0);
            rc = ($urandom_range(59, 0) == 0);
            if ($urandom_range(15, 0) == 0)      rd = $urandom;
            else if (mode)                       rd = $urandom_range(80, rhi - 2);
            else                                 rd = $urandom_range(rlo + 2, 20);
            applyStimulus(rv, rc, rd, rhi, rlo);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
